instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 131 +++++++++++++
 tb/tb_instr_fetch.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: a single-outstanding-read fetch FSM feeding a small FIFO toward decode.
// Optional stall counter on perfStall is enabled by defining FETCH_PERF_EN.
module instr_fetch #(
   parameter int IW    = 16,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    pcAddress,
   input  logic          sigBranch,
   output logic          pcNext,
   output logic          memReq,
   output logic [7:0]    memAddr,
   input  logic          memAck,
   input  logic [IW-1:0] memData,
   output logic [IW-1:0] instr,
   output logic [7:0]    instrPc,
   output logic          instrValid,
   input  logic          instrReady,
   output logic [7:0]    perfStall
);
   // state | meaning
   // IDLE  | no read outstanding
   // REQ   | live read outstanding, response will be queued
   // FLUSH | read outstanding whose response is discarded after a branch
   typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

   localparam int PW = (DEPTH > 2) ? 2 : 1;
   localparam int CW = (DEPTH == 4) ? 3 : 2;

   state_t          state, state_nxt;
   logic [IW-1:0]   q_data [DEPTH];
   logic [7:0]      q_pc   [DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   count, count_ap;
   logic            pop, push, issue;
   logic [IW-1:0]   last_instr;
   logic [7:0]      last_pc;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign instrValid = (count != '0);
   assign pop        = instrValid && instrReady;
   assign count_ap   = count - CW'(pop);
   assign memReq     = (state != IDLE);
   assign pcNext     = issue && !reset;
   assign instr      = instrValid ? q_data[rd_ptr] : last_instr;
   assign instrPc    = instrValid ? q_pc[rd_ptr]   : last_pc;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Free-slot decisions use the occupancy after this cycle's pop.
   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (!sigBranch && (count_ap < CW'(DEPTH))) begin
               issue     = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (sigBranch) begin
               state_nxt = memAck ? IDLE : FLUSH;
            end else if (memAck) begin
               push = 1'b1;
               if ((count_ap + CW'(1)) < CW'(DEPTH)) issue = 1'b1;
               else                                   state_nxt = IDLE;
            end
         end
         FLUSH: begin
            if (memAck) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         memAddr    <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         last_instr <= '0;
         last_pc    <= '0;
      end else begin
         if (issue) memAddr <= pcAddress;
         if (instrValid) begin
            last_instr <= q_data[rd_ptr];
            last_pc    <= q_pc[rd_ptr];
         end
         if (sigBranch) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_data[wr_ptr] <= memData;
         q_pc[wr_ptr]   <= memAddr;
      end
   end

`ifdef FETCH_PERF_EN
   logic [7:0] stall_cnt;
   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt <= '0;
      else if (instrReady && !instrValid && (stall_cnt != 8'hFF))
         stall_cnt <= stall_cnt + 8'd1;
   end
   assign perfStall = stall_cnt;
`else
   assign perfStall = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised bench for instr_fetch: transaction-level reference model plus a scoreboard of expected
// instructions popped by an independent monitor.
module tb_instr_fetch;
   localparam int IW    = 16;
   localparam int DEPTH = 2;
`ifdef FETCH_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    pcAddress;
   logic          sigBranch;
   logic          pcNext;
   logic          memReq;
   logic [7:0]    memAddr;
   logic          memAck;
   logic [IW-1:0] memData;
   logic [IW-1:0] instr;
   logic [7:0]    instrPc;
   logic          instrValid;
   logic          instrReady;
   logic [7:0]    perfStall;

   instr_fetch #(.IW(IW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .pcAddress(pcAddress), .sigBranch(sigBranch),
      .pcNext(pcNext), .memReq(memReq), .memAddr(memAddr), .memAck(memAck),
      .memData(memData), .instr(instr), .instrPc(instrPc), .instrValid(instrValid),
      .instrReady(instrReady), .perfStall(perfStall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IW-1:0] d;
      logic [7:0]    a;
   } entry_t;

   entry_t        sb[$];
   int            checks = 0;
   int            errors = 0;
   logic [IW-1:0] last_d = '0;
   logic [7:0]    last_a = '0;
   int            exp_stall = 0;
   bit            out_live = 0, out_dead = 0;
   logic [7:0]    out_addr = '0;

   int            p_br = 0, p_ack = 100, p_rdy = 100;
   bit            fix_tgt = 0;
   logic [7:0]    tgt = '0;
   logic [7:0]    pc_init = 8'h10;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: presents/pops the scoreboard head and checks the decode-side outputs.
   initial begin
      bit exp_v;
      @(posedge clk);
      forever begin
         @(negedge clk);
         exp_v = (sb.size() != 0);
         chk("instrValid", 32'(instrValid), 32'(exp_v));
         if (exp_v) begin
            chk("instr", 32'(instr), 32'(sb[0].d));
            chk("instrPc", 32'(instrPc), 32'(sb[0].a));
            last_d = sb[0].d;
            last_a = sb[0].a;
            if (instrReady) void'(sb.pop_front());
         end else begin
            chk("instr_hold", 32'(instr), 32'(last_d));
            chk("instrPc_hold", 32'(instrPc), 32'(last_a));
         end
         chk("perfStall", 32'(perfStall), 32'(exp_stall));
         if (reset) exp_stall = 0;
         else if (PERF && instrReady && !exp_v && exp_stall < 255) exp_stall++;
      end
   end

   // Reference model of the outstanding read and issue decisions.
   initial begin
      bit busy, exp_pn;
      int entries;
      @(posedge clk);
      forever begin
         @(negedge clk);
         #1;
         entries = sb.size();
         busy    = out_live || out_dead;
         exp_pn  = 0;
         chk("memReq", 32'(memReq), 32'(busy));
         if (busy) chk("memAddr", 32'(memAddr), 32'(out_addr));
         if (!busy) begin
            exp_pn = !sigBranch && (entries < DEPTH);
         end else if (out_live) begin
            if (sigBranch) begin
               out_live = 0;
               out_dead = !memAck;
            end else if (memAck) begin
               sb.push_back('{d: memData, a: out_addr});
               if (entries + 1 < DEPTH) exp_pn = 1;
               else                     out_live = 0;
            end
         end else if (memAck) begin
            out_dead = 0;
         end
         if (sigBranch) sb.delete();
         if (exp_pn) begin
            out_live = 1;
            out_addr = pcAddress;
         end
         chk("pcNext", 32'(pcNext), 32'(exp_pn && !reset));
         if (reset) begin
            sb.delete();
            out_live = 0;
            out_dead = 0;
            last_d   = '0;
            last_a   = '0;
         end
      end
   end

   // One cycle of environment: PC counter follows pcNext/branches, other inputs randomised.
   task automatic step();
      logic s_pn, s_br, s_rst;
      @(negedge clk);
      s_pn  = pcNext;
      s_br  = sigBranch;
      s_rst = reset;
      @(posedge clk);
      #1;
      if (s_rst)     pcAddress = pc_init;
      else if (s_br) pcAddress = tgt;
      else if (s_pn) pcAddress = pcAddress + 8'd1;
      sigBranch  = ($urandom_range(99) < p_br);
      memAck     = ($urandom_range(99) < p_ack);
      instrReady = ($urandom_range(99) < p_rdy);
      memData    = IW'($urandom);
      tgt        = fix_tgt ? 8'h40 : 8'($urandom);
   endtask

   initial begin
      reset = 1'b1; pcAddress = pc_init; sigBranch = 0; memAck = 1;
      memData = 16'hA5A5; instrReady = 1;
      repeat (3) step();
      reset = 1'b0;
      repeat (12) step();

      p_rdy = 0;
      repeat (12) step();
      p_rdy = 100;
      repeat (6) step();

      fix_tgt = 1; p_ack = 0;
      repeat (2) step();
      p_br = 100;
      step();
      p_br = 0;
      repeat (3) step();
      p_ack = 100;
      repeat (8) step();
      fix_tgt = 0;

      p_br = 8; p_ack = 50; p_rdy = 60;
      repeat (4000) step();
      p_br = 30; p_ack = 70; p_rdy = 40;
      repeat (2000) step();

      p_br = 0; p_ack = 0; p_rdy = 100;
      repeat (3) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (300) step();
      @(negedge clk);
      chk("perf_saturate", 32'(perfStall), PERF ? 32'd255 : 32'd0);
      chk("memReq_stuck", 32'(memReq), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
